// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver now, transmitter later).
//   - FSM state encoding as plain localparam constants
//   - default frame geometry (data bits, stop-bit oversample ticks)
//   - clog2 helper used to size bit counters at elaboration time
// ---------------------------------------------------------------------------
package uart_pkg;

    // FSM state encoding. Kept as sized constants so older code that
    // compares raw state vectors keeps working.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    // Default frame geometry: 8 data bits, one stop bit (16 oversample ticks).
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

    // Ceiling log2 for counter sizing; clog2(1) = 0, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// ---------------------------------------------------------------------------
// uart_rx_os16_if
// Signal bundle between the serial-line side and the byte consumer of the
// 16x-oversampling UART receiver.
//   rx            raw serial line, idles high, asynchronous to clk
//   s_tick        one-clk pulse at 16x the baud rate
//   dout          received data word, held until the next rx_done_tick
//   rx_done_tick  one-clk strobe: dout and both error flags are valid
//   frame_err     stop bit sampled low
//   parity_err    parity mismatch (always 0 when parity is not built in)
// Modports:
//   master  the receiver itself (consumes rx/s_tick, produces the word)
//   slave   the environment (drives rx/s_tick, consumes the word)
// ---------------------------------------------------------------------------
interface uart_rx_os16_if #(
    parameter int DBIT = uart_pkg::DBIT_DEFAULT
);

    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    modport master (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output frame_err,
        output parity_err
    );

    modport slave (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  frame_err,
        input  parity_err
    );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input pin.
// The reset value is a parameter so idle-high lines (UART RX) do not look
// like an active edge while the chip comes out of reset.
// Ports:
//   clk      destination clock
//   reset_n  asynchronous active-low reset
//   d        asynchronous input
//   q        synchronized output, 2 clk latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// ---------------------------------------------------------------------------
// uart_rx_os16
// UART receiver driven by a 16x-oversampling tick. Recovers 8N1 frames
// (8E1/8O1 when the parity stage is built in) from the serial line and
// hands each word to the command parser with a one-clk strobe.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> parity bit expected between the last
//                                   data bit and the stop bit; parity_err
//                                   reports a mismatch
//                      undefined -> no parity bit; parity_err tied to 0
//
// Parameters:
//   DBIT     data bits per frame, LSB first (5..8)
//   SB_TICK  oversample ticks spent in the stop bit (16/24/32 = 1/1.5/2)
//   PAR_ODD  parity sense, 0 = even, 1 = odd (parity build only)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_os16_if.master: rx, s_tick in; dout, rx_done_tick,
//            frame_err, parity_err out
//
// Timing: the line is sampled in the middle of each bit (tick 7 of the
// start bit, then every 16 ticks). rx_done_tick rises one clk after the
// s_tick that ends the stop bit. A framing error still delivers dout.
// ---------------------------------------------------------------------------
module uart_rx_os16 import uart_pkg::*; #(
    parameter int   DBIT    = DBIT_DEFAULT,
    parameter int   SB_TICK = SB_TICK_DEFAULT,
    parameter logic PAR_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_rx_os16_if.master    bus
);

    // Bit counter width; at least one bit even for degenerate DBIT values.
    localparam int NW = (clog2(DBIT) < 1) ? 1 : clog2(DBIT);

    // Last index values for the counters. s is 5 bits so a 2-stop-bit
    // setting (SB_TICK = 32) still fits; the start/data/parity phases never
    // count past 15 because every phase exit clears s.
    localparam logic [4:0]    S_MID_START = 5'd7;
    localparam logic [4:0]    S_LAST_BIT  = 5'd15;
    localparam logic [4:0]    S_LAST_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = PAR;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    // -----------------------------------------------------------------------
    // Line synchronizer. Resets to 1 (idle line) so reset release is not
    // mistaken for a start edge.
    // -----------------------------------------------------------------------
    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.rx),
        .q       (rx_s)
    );

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [2:0]      state_q,  state_d;
    logic [4:0]      s_q,      s_d;     // oversample tick counter
    logic [NW-1:0]   n_q,      n_d;     // data bit index
    logic [DBIT-1:0] b_q,      b_d;     // data shift register, LSB first
    logic [DBIT-1:0] dout_q,   dout_d;
    logic            done_q,   done_d;
    logic            ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            p_q,      p_d;     // received parity bit
    logic            perr_q,   perr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the edge, regardless of statement order.
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A phase exit always clears s, so a tick arriving in
    // the same clk as a transition never increments it.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first; without it a path that
        // skips an assignment would infer a latch.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
        perr_d  = perr_q;
`endif

        case (state_q)
            IDLE: begin
                // Ticks are ignored here; any low level arms the start check.
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_MID_START) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            // Line went back high before mid-bit: glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = AFTER_DATA;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d     = '0;
                        p_d     = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif

            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST_STOP) begin
                        state_d = IDLE;
                        s_d     = '0;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Data ones plus parity bit must match the chosen sense.
                        perr_d  = (^b_q) ^ p_q ^ PAR_ODD;
`endif
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;

`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`else
    assign bus.parity_err   = 1'b0;

    // Parity sense has no effect when no parity bit is received.
    logic unused_par_odd;
    assign unused_par_odd = PAR_ODD;
`endif

endmodule
